// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the uart TX FIFO write port.
// A client owns the TX path from grant until its i_last byte is written (or a
// stall timeout). An optional header byte tags each packet with its source.
module uart_tx_arbiter #(
    parameter int unsigned           NumClients    = 4,
    parameter int unsigned           DataLength    = 8,
    parameter bit                    HeaderEn      = 1'b1,
    parameter logic [DataLength-1:0] HeaderBase    = 8'hF0,
    parameter int unsigned           TimeoutCycles = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NumClients-1:0]            i_valid,
    input  logic [NumClients*DataLength-1:0] i_data,
    input  logic [NumClients-1:0]            i_last,
    output logic [NumClients-1:0]            o_ready,
    output logic [DataLength-1:0]            o_tx_data,
    output logic                             o_tx_req,
    input  logic                             i_tx_rdy,
    output logic [NumClients-1:0]            o_grant,
    output logic                             o_busy,
    output logic                             o_timeout
);

    localparam int unsigned IdxW = (NumClients > 1) ? $clog2(NumClients) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    // Counter value on the cycle whose stall makes the count reach TimeoutCycles.
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StData
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [NumClients-1:0]   grant_q, grant_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic                    win_found;
    logic [IdxW-1:0]         win_idx;
    logic [31:0]             cand;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DataLength-1:0]   sel_data;
    logic                    tx_fire;

    // Round-robin search starting just after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NumClients; i++) begin
            cand = (32'(ptr_q) + 32'(i)) % NumClients;
            if (!win_found && i_valid[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end

    // Granted-client view of the request inputs.
    always_comb begin
        sel_valid = i_valid[idx_q];
        sel_last  = i_last[idx_q];
        sel_data  = i_data[32'(idx_q)*DataLength +: DataLength];
    end

    // Next-state, timeout counting and TX-side outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        tx_fire   = 1'b0;
        o_tx_data = '0;
        o_tx_req  = 1'b0;
        o_ready   = '0;
        o_timeout = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    grant_d = NumClients'(1) << win_idx;
                    cnt_d   = '0;
                    state_d = HeaderEn ? StHeader : StData;
                end
            end

            StHeader: begin
                // Header goes out regardless of the client's current i_valid.
                o_tx_data = HeaderBase | DataLength'(idx_q);
                o_tx_req  = i_tx_rdy;
                if (i_tx_rdy) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end

            StData: begin
                o_tx_data = sel_data;
                o_ready   = grant_q & {NumClients{i_tx_rdy}};
                tx_fire   = sel_valid & i_tx_rdy;
                o_tx_req  = tx_fire;
                if (tx_fire) begin
                    cnt_d = '0;
                    if (sel_last) begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else if (!sel_valid && (TimeoutCycles != 0)) begin
                    // Only client stalls count; FIFO backpressure holds the count.
                    if (cnt_q == CntLast) begin
                        o_timeout = 1'b1;
                        cnt_d     = '0;
                        grant_d   = '0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers; pointer resets to the last client so client 0 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= IdxW'(NumClients - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        o_grant = grant_q;
        o_busy  = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-client byte queues feed the DUT,
// expected FIFO writes are queued by the stimulus and checked by a monitor.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid, last, ready, grant;
    logic [31:0] data;
    logic [7:0]  tx_data;
    logic        tx_req, tx_rdy, busy, timeout;

    // Second instance: no header, timeout disabled.
    logic [3:0]  nh_valid, nh_last, nh_ready, nh_grant;
    logic [31:0] nh_data;
    logic [7:0]  nh_tx_data;
    logic        nh_tx_req, nh_busy, nh_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int timeouts = 0;
    bit rdy_mode = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;

    logic [8:0] cq [4][$];   // per-client {last, data}
    logic [7:0] exp_q [$];   // expected FIFO writes, in order

    uart_tx_arbiter #(
        .NumClients(4), .DataLength(8), .HeaderEn(1'b1), .HeaderBase(8'hF0), .TimeoutCycles(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
        .o_ready(ready), .o_tx_data(tx_data), .o_tx_req(tx_req), .i_tx_rdy(tx_rdy),
        .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
    );

    uart_tx_arbiter #(
        .NumClients(4), .DataLength(8), .HeaderEn(1'b0), .HeaderBase(8'hF0), .TimeoutCycles(0)
    ) dut_nh (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(nh_valid), .i_data(nh_data), .i_last(nh_last),
        .o_ready(nh_ready), .o_tx_data(nh_tx_data), .o_tx_req(nh_tx_req), .i_tx_rdy(1'b1),
        .o_grant(nh_grant), .o_busy(nh_busy), .o_timeout(nh_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic present();
        for (int k = 0; k < 4; k++) begin
            if (cq[k].size() > 0) begin
                valid[k]        = 1'b1;
                data[k*8 +: 8]  = cq[k][0][7:0];
                last[k]         = cq[k][0][8];
            end else begin
                valid[k]        = 1'b0;
                data[k*8 +: 8]  = 8'h00;
                last[k]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l);
        cq[k].push_back({l, b});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Client driver: handshakes sampled mid-cycle, queues advanced after the edge.
    initial begin
        logic [3:0] hs;
        forever begin
            @(negedge clk);
            hs = valid & ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                if (hs[k] && cq[k].size() > 0) void'(cq[k].pop_front());
            tx_rdy = rdy_mode ? rdy_pat[cyc % 4] : 1'b1;
            present();
        end
    end

    // Monitor: every FIFO write is compared against the head of the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_req) begin
            chk("req_needs_rdy", {31'd0, tx_rdy}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %0h required no write", tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
            last_wr_cyc = cyc;
        end
        if (|ready) chk("ready_needs_rdy", {31'd0, tx_rdy}, 32'd1);
        if (timeout) begin
            timeouts++;
            chk("timeout_delay", cyc - last_wr_cyc, 32'd8);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n    = 1'b0;
        valid    = '0; data = '0; last = '0; tx_rdy = 1'b1;
        nh_valid = '0; nh_data = '0; nh_last = '0;
        #12;
        chk("rst_grant", {28'd0, grant}, 0);
        chk("rst_ready", {28'd0, ready}, 0);
        chk("rst_req", {31'd0, tx_req}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_nh_busy", {31'd0, nh_busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: client 2, header then three bytes back to back.
        @(posedge clk); #2;
        exp_q.push_back(8'hF2); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
        present();
        @(negedge clk);
        chk("t1_idle_req", {31'd0, tx_req}, 0);
        chk("t1_idle_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_consecutive_req", {31'd0, tx_req}, 1);
        end
        @(negedge clk);
        chk("t1_busy_drop", {31'd0, busy}, 0);
        wait_drain(5, "t1");

        // 2: clients 0 and 1 contend with two 2-byte packets each.
        @(posedge clk); #2;
        exp_q = '{8'hF0, 8'h01, 8'h02, 8'hF1, 8'h41, 8'h42,
                  8'hF0, 8'h03, 8'h04, 8'hF1, 8'h43, 8'h44};
        push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(1, 8'h41, 0); push(1, 8'h42, 1); push(1, 8'h43, 0); push(1, 8'h44, 1);
        present();
        wait_drain(60, "t2");

        // 3: client 3 streams under toggling FIFO ready.
        @(posedge clk); #2;
        rdy_mode = 1'b1;
        exp_q = '{8'hF3, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        for (int i = 1; i <= 6; i++) push(3, 8'hC0 + 8'(i), (i == 6));
        present();
        wait_drain(80, "t3");
        rdy_mode = 1'b0;
        chk("t3_no_timeout", timeouts, 0);
        @(posedge clk); #2;

        // 4: client 1 stalls mid-packet while client 2 waits.
        exp_q = '{8'hF1, 8'h61, 8'hF2, 8'h71, 8'h72};
        push(1, 8'h61, 0);
        push(2, 8'h71, 0); push(2, 8'h72, 1);
        present();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (timeout) seen = 1'b1;
        end
        chk("t4_timeout_seen", {31'd0, seen}, 1);
        @(negedge clk);
        chk("t4_idle_grant", {28'd0, grant}, 0);
        @(negedge clk);
        chk("t4_grant_c2", {28'd0, grant}, 4'b0100);
        wait_drain(20, "t4");
        chk("t4_timeout_count", timeouts, 1);

        // 5: headerless instance, single-byte packets back to back from client 1.
        @(posedge clk); #2;
        nh_valid = 4'b0010; nh_last = 4'b0010; nh_data[15:8] = 8'h5A;
        @(negedge clk);
        chk("t5_idle_req", {31'd0, nh_tx_req}, 0);
        chk("t5_idle_grant", {28'd0, nh_grant}, 0);
        @(negedge clk);
        chk("t5_req", {31'd0, nh_tx_req}, 1);
        chk("t5_data", {24'd0, nh_tx_data}, 8'h5A);
        chk("t5_grant", {28'd0, nh_grant}, 4'b0010);
        @(posedge clk); #2;
        nh_data[15:8] = 8'hA5;
        @(negedge clk);
        chk("t5_back_idle_req", {31'd0, nh_tx_req}, 0);
        chk("t5_back_idle_busy", {31'd0, nh_busy}, 0);
        @(negedge clk);
        chk("t5_rearb_req", {31'd0, nh_tx_req}, 1);
        chk("t5_rearb_data", {24'd0, nh_tx_data}, 8'hA5);
        @(posedge clk); #2;
        nh_valid = '0; nh_last = '0;
        @(negedge clk);
        chk("t5_end_busy", {31'd0, nh_busy}, 0);

        // 6: reset in the middle of a client 0 packet.
        @(posedge clk); #2;
        exp_q = '{8'hF0, 8'h81};
        push(0, 8'h81, 0); push(0, 8'h82, 0); push(0, 8'h83, 0); push(0, 8'h84, 1);
        present();
        wait_drain(10, "t6a");
        chk("t6_busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", {28'd0, grant}, 0);
        chk("t6_rst_ready", {28'd0, ready}, 0);
        chk("t6_rst_req", {31'd0, tx_req}, 0);
        chk("t6_rst_data", {24'd0, tx_data}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        for (int k = 0; k < 4; k++) cq[k].delete();
        exp_q.delete();
        present();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        exp_q = '{8'hF0, 8'h90, 8'hF1, 8'h91, 8'hF2, 8'h92, 8'hF3, 8'h93};
        for (int k = 0; k < 4; k++) push(k, 8'h90 + 8'(k), 1);
        present();
        @(negedge clk);
        chk("t6_arb_idle", {28'd0, grant}, 0);
        @(negedge clk);
        chk("t6_grant_c0", {28'd0, grant}, 4'b0001);
        wait_drain(40, "t6b");

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
